// File: rtl/big_core_pkg.sv
// Shared constants for the R-type execute block: RV32 opcode, funct fields, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package big_core_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;  // SUB / SRA

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;  // SRA when funct7 = F7_ALT
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    SHIFT = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/big_core_rtype_rf.sv
// 32x32 register file: two combinational reads, one synchronous write, x0 hardwired to 0.
// Latency: reads 0 cycles, write visible after the next rising edge.
// Backpressure: none; a write is taken every cycle wr_en is high.
// Ports: clk/rst_n (sync active-low, clears every entry), rd_a_*/rd_b_* read ports,
//        wr_en/wr_addr/wr_data write port (writes to x0 are dropped).
module big_core_rtype_rf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rd_a_addr,
  output logic [31:0] rd_a_data,
  input  logic [4:0]  rd_b_addr,
  output logic [31:0] rd_b_data,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data
);

  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_a_data = (rd_a_addr == 5'd0) ? 32'd0 : mem[rd_a_addr];
  assign rd_b_data = (rd_b_addr == 5'd0) ? 32'd0 : mem[rd_b_addr];

endmodule

// File: rtl/big_core_rtype_exec.sv
// Executes one RV32 R-type ALU instruction at a time against a local register file.
// Latency: accept at T -> response at T+2; serial shifts add one cycle per shift bit.
// Backpressure: CmdReady only in IDLE; response held stable in RESP until RspReady.
// Ports: Clk/RstN (sync active-low), CmdValid/CmdReady/Command in, RspValid/RspReady/
//        RspRd/RspData/RspIllegal out, DbgWr* preload (IDLE only), DbgRdAddr/DbgRdData read.
module big_core_rtype_exec
  import big_core_pkg::*;
#(
  parameter int SERIAL_SHIFT = 1
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [31:0] Command,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [4:0]  RspRd,
  output logic [31:0] RspData,
  output logic        RspIllegal,
  input  logic        DbgWrEn,
  input  logic [4:0]  DbgWrAddr,
  input  logic [31:0] DbgWrData,
  input  logic [4:0]  DbgRdAddr,
  output logic [31:0] DbgRdData
);

  state_t      state, state_nxt;
  logic [31:0] cmd_q;
  logic [4:0]  shift_cnt;
  logic [31:0] shift_val;
  logic [4:0]  rsp_rd_q;
  logic [31:0] rsp_data_q;
  logic        rsp_illegal_q;

  // Instruction fields of the latched command
  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opcode = cmd_q[6:0];
  assign rd     = cmd_q[11:7];
  assign f3     = cmd_q[14:12];
  assign rs1    = cmd_q[19:15];
  assign rs2    = cmd_q[24:20];
  assign f7     = cmd_q[31:25];

  logic [31:0] rs1_val, rs2_val, rd_b_data;
  logic [4:0]  rd_b_addr, shamt;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  // Port B serves rs2 during the single EXEC cycle and the debug read otherwise.
  assign rd_b_addr = (state == EXEC) ? rs2 : DbgRdAddr;
  assign rs2_val   = rd_b_data;
  assign DbgRdData = rd_b_data;
  assign shamt     = rs2_val[4:0];

  big_core_rtype_rf u_rf (
    .clk       (Clk),
    .rst_n     (RstN),
    .rd_a_addr (rs1),
    .rd_a_data (rs1_val),
    .rd_b_addr (rd_b_addr),
    .rd_b_data (rd_b_data),
    .wr_en     (rf_wr_en),
    .wr_addr   (rf_wr_addr),
    .wr_data   (rf_wr_data)
  );

  logic is_alt, legal, is_shift, serial_start;
  assign is_alt   = (f7 == F7_ALT);
  assign legal    = (opcode == OPC_RTYPE) &&
                    ((f7 == F7_BASE) || (is_alt && ((f3 == F3_ADD) || (f3 == F3_SRL))));
  assign is_shift = (f3 == F3_SLL) || (f3 == F3_SRL);
  assign serial_start = (SERIAL_SHIFT != 0) && legal && is_shift && (shamt != 5'd0);

  logic [31:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (f3)
      F3_ADD:  alu_res = is_alt ? (rs1_val - rs2_val) : (rs1_val + rs2_val);
      F3_SLL:  alu_res = rs1_val << shamt;
      F3_SLT:  alu_res = {31'd0, $signed(rs1_val) < $signed(rs2_val)};
      F3_SLTU: alu_res = {31'd0, rs1_val < rs2_val};
      F3_XOR:  alu_res = rs1_val ^ rs2_val;
      F3_SRL:  alu_res = is_alt ? $unsigned($signed(rs1_val) >>> shamt) : (rs1_val >> shamt);
      F3_OR:   alu_res = rs1_val | rs2_val;
      F3_AND:  alu_res = rs1_val & rs2_val;
      default: alu_res = '0;
    endcase
  end

  // One-bit step of the serial shifter; direction/fill come from the latched command.
  logic [31:0] shift_step;
  always_comb begin
    shift_step = {1'b0, shift_val[31:1]};
    if (f3 == F3_SLL)  shift_step = {shift_val[30:0], 1'b0};
    else if (is_alt)   shift_step = {shift_val[31], shift_val[31:1]};
  end

  logic        wb_en;
  logic [31:0] wb_data;
  always_comb begin
    state_nxt = state;
    wb_en     = 1'b0;
    wb_data   = alu_res;
    case (state)
      IDLE: if (CmdValid) state_nxt = EXEC;
      EXEC: begin
        if (serial_start) begin
          state_nxt = SHIFT;
        end else begin
          state_nxt = RESP;
          wb_en     = legal;
        end
      end
      SHIFT: begin
        wb_data = shift_step;
        if (shift_cnt == 5'd1) begin
          state_nxt = RESP;
          wb_en     = 1'b1;
        end
      end
      RESP: if (RspReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Debug writes only in IDLE, where the writeback path is guaranteed inactive.
  assign rf_wr_en   = wb_en || ((state == IDLE) && DbgWrEn);
  assign rf_wr_addr = wb_en ? rd : DbgWrAddr;
  assign rf_wr_data = wb_en ? wb_data : DbgWrData;

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      state         <= IDLE;
      cmd_q         <= '0;
      shift_cnt     <= '0;
      shift_val     <= '0;
      rsp_rd_q      <= '0;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (CmdValid) cmd_q <= Command;
        EXEC: begin
          if (serial_start) begin
            shift_val <= rs1_val;
            shift_cnt <= shamt;
          end else begin
            rsp_rd_q      <= rd;
            rsp_data_q    <= legal ? alu_res : 32'd0;
            rsp_illegal_q <= !legal;
          end
        end
        SHIFT: begin
          shift_val <= shift_step;
          shift_cnt <= shift_cnt - 5'd1;
          if (shift_cnt == 5'd1) begin
            rsp_rd_q      <= rd;
            rsp_data_q    <= shift_step;
            rsp_illegal_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign CmdReady   = (state == IDLE);
  assign RspValid   = (state == RESP);
  assign RspRd      = RspValid ? rsp_rd_q : 5'd0;
  assign RspData    = RspValid ? rsp_data_q : 32'd0;
  assign RspIllegal = RspValid ? rsp_illegal_q : 1'b0;

endmodule

// File: tb/tb_big_core_rtype_exec.sv
module tb_big_core_rtype_exec;

  logic        Clk = 1'b0;
  logic        RstN;
  logic        CmdValid, CmdReady;
  logic [31:0] Command;
  logic        RspValid, RspReady, RspIllegal;
  logic [4:0]  RspRd;
  logic [31:0] RspData;
  logic        DbgWrEn;
  logic [4:0]  DbgWrAddr, DbgRdAddr;
  logic [31:0] DbgWrData, DbgRdData;

  // Second instance with the single-cycle shifter
  logic        s0_cmd_vld, s0_cmd_rdy, s0_rsp_vld, s0_rsp_rdy, s0_rsp_ill, s0_wr_en;
  logic [31:0] s0_cmd, s0_rsp_dat, s0_wr_dat, s0_rd_dat;
  logic [4:0]  s0_rsp_rd, s0_wr_addr, s0_rd_addr;

  always #5 Clk = ~Clk;

  big_core_rtype_exec #(.SERIAL_SHIFT(1)) u_dut (
    .Clk(Clk), .RstN(RstN), .CmdValid(CmdValid), .CmdReady(CmdReady), .Command(Command),
    .RspValid(RspValid), .RspReady(RspReady), .RspRd(RspRd), .RspData(RspData),
    .RspIllegal(RspIllegal), .DbgWrEn(DbgWrEn), .DbgWrAddr(DbgWrAddr), .DbgWrData(DbgWrData),
    .DbgRdAddr(DbgRdAddr), .DbgRdData(DbgRdData)
  );

  big_core_rtype_exec #(.SERIAL_SHIFT(0)) u_dut0 (
    .Clk(Clk), .RstN(RstN), .CmdValid(s0_cmd_vld), .CmdReady(s0_cmd_rdy), .Command(s0_cmd),
    .RspValid(s0_rsp_vld), .RspReady(s0_rsp_rdy), .RspRd(s0_rsp_rd), .RspData(s0_rsp_dat),
    .RspIllegal(s0_rsp_ill), .DbgWrEn(s0_wr_en), .DbgWrAddr(s0_wr_addr), .DbgWrData(s0_wr_dat),
    .DbgRdAddr(s0_rd_addr), .DbgRdData(s0_rd_dat)
  );

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        illegal;
    int          issue;
    int          lat;
    int          hold;
    logic [31:0] rf_after;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] ref_rf [32];

  logic       mon_on = 1'b0;
  logic [4:0] mon_addr = '0;
  logic [4:0] stim_addr;
  assign DbgRdAddr = mon_on ? mon_addr : stim_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Reference: instruction semantics straight from the RV32 R-type definitions.
  function automatic void ref_alu(input logic [31:0] cmd, input logic [31:0] a,
                                  input logic [31:0] b, output bit legal,
                                  output logic [31:0] res, output int extra);
    logic [6:0] f7;
    logic [2:0] f3;
    int n;
    f7 = cmd[31:25];
    f3 = cmd[14:12];
    n = int'(b[4:0]);
    res = 32'd0;
    extra = 0;
    legal = (cmd[6:0] == 7'h33) &&
            ((f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    if (!legal) return;
    case (f3)
      3'd0: res = (f7 == 7'h20) ? a - b : a + b;
      3'd1: res = a << n;
      3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: res = (a < b) ? 32'd1 : 32'd0;
      3'd4: res = a ^ b;
      3'd5: begin
        if (f7 == 7'h20) begin
          for (int i = 0; i < 32; i++) res[i] = (i + n < 32) ? a[i + n] : a[31];
        end else begin
          res = a >> n;
        end
      end
      3'd6: res = a | b;
      default: res = a & b;
    endcase
    if (f3 == 3'd1 || f3 == 3'd5) extra = n;
  endfunction

  // Monitor: pops the scoreboard whenever a response appears and applies backpressure.
  initial begin
    exp_t e;
    RspReady = 1'b0;
    forever begin
      @(negedge Clk);
      if (RspValid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", RspValid, 1'b0);
          RspReady = 1'b1;
          @(negedge Clk);
          RspReady = 1'b0;
        end else begin
          e = sb.pop_front();
          chk("rsp_rd", RspRd, e.rd);
          chk("rsp_data", RspData, e.data);
          chk("rsp_illegal", RspIllegal, e.illegal);
          chk("rsp_latency", cyc - e.issue, e.lat);
          mon_addr = e.rd;
          mon_on = 1'b1;
          #1;
          chk("rf_writeback", DbgRdData, e.rf_after);
          mon_on = 1'b0;
          for (int k = 0; k < e.hold; k++) begin
            @(negedge Clk);
            chk("hold_stable", {RspValid, CmdReady, RspIllegal, RspRd, RspData},
                {1'b1, 1'b0, e.illegal, e.rd, e.data});
          end
          RspReady = 1'b1;
          @(negedge Clk);
          RspReady = 1'b0;
          chk("post_rsp_idle", {RspValid, RspIllegal, RspRd, RspData}, 39'd0);
        end
      end
    end
  end

  task automatic dbg_wr(input logic [4:0] a, input logic [31:0] d);
    DbgWrEn = 1'b1;
    DbgWrAddr = a;
    DbgWrData = d;
    @(negedge Clk);
    DbgWrEn = 1'b0;
    if (a != 5'd0) ref_rf[a] = d;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a);
    stim_addr = a;
    #1;
    chk(name, DbgRdData, ref_rf[a]);
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((sb.size() != 0 || !CmdReady) && w < 1000) begin
      @(negedge Clk);
      w++;
    end
    chk("idle_reached", {sb.size() == 0, CmdReady}, 2'b11);
  endtask

  task automatic issue(input logic [31:0] cmd, input int hold, input bit poke);
    exp_t e;
    bit lg;
    logic [31:0] res;
    int extra;
    int w = 0;
    ref_alu(cmd, ref_rf[cmd[19:15]], ref_rf[cmd[24:20]], lg, res, extra);
    Command = cmd;
    CmdValid = 1'b1;
    while (!CmdReady && w < 300) begin
      @(negedge Clk);
      w++;
    end
    if (!CmdReady) begin
      chk("cmd_accept_timeout", CmdReady, 1'b1);
      CmdValid = 1'b0;
      return;
    end
    e.rd = cmd[11:7];
    e.illegal = !lg;
    e.data = lg ? res : 32'd0;
    e.issue = cyc;
    e.lat = 2 + extra;
    e.hold = hold;
    if (lg && e.rd != 5'd0) ref_rf[e.rd] = res;
    e.rf_after = ref_rf[e.rd];
    sb.push_back(e);
    @(negedge Clk);
    CmdValid = 1'b0;
    Command = $urandom();
    if (poke) begin
      // Lands on an EXEC edge and must be dropped
      DbgWrEn = 1'b1;
      DbgWrAddr = 5'd20;
      DbgWrData = 32'hDEAD_BEEF;
      @(negedge Clk);
      DbgWrEn = 1'b0;
    end
  endtask

  task automatic s0_run(input string name, input logic [31:0] cmd,
                        input logic [31:0] a, input logic [31:0] b);
    bit lg;
    logic [31:0] res;
    int extra;
    int n = 1;
    ref_alu(cmd, a, b, lg, res, extra);
    s0_cmd = cmd;
    s0_cmd_vld = 1'b1;
    @(negedge Clk);
    s0_cmd_vld = 1'b0;
    while (!s0_rsp_vld && n < 40) begin
      @(negedge Clk);
      n++;
    end
    chk({name, "_latency"}, n, 2);
    chk({name, "_data"}, s0_rsp_dat, res);
    s0_rsp_rdy = 1'b1;
    @(negedge Clk);
    s0_rsp_rdy = 1'b0;
  endtask

  initial begin
    logic [31:0] cmd;
    logic [6:0]  f7;
    int          k, seen;
    RstN = 1'b0;
    CmdValid = 1'b0;
    Command = '0;
    DbgWrEn = 1'b0;
    DbgWrAddr = '0;
    DbgWrData = '0;
    stim_addr = '0;
    s0_cmd_vld = 1'b0; s0_cmd = '0; s0_rsp_rdy = 1'b0;
    s0_wr_en = 1'b0; s0_wr_addr = '0; s0_wr_dat = '0; s0_rd_addr = '0;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;

    repeat (3) @(negedge Clk);
    RstN = 1'b1;
    chk("reset_cmd_ready", CmdReady, 1'b1);
    chk("reset_rsp_fields", {RspValid, RspIllegal, RspRd, RspData}, 39'd0);
    rd_chk("reset_rf_x10", 5'd10);

    dbg_wr(5'd1, 32'd10);
    dbg_wr(5'd2, 32'd20);
    dbg_wr(5'd3, 32'd5);
    dbg_wr(5'd4, 32'd15);
    dbg_wr(5'd5, 32'hFFFF_FFF8);
    dbg_wr(5'd0, 32'd123);
    rd_chk("preload_x5", 5'd5);
    rd_chk("x0_after_dbg_write", 5'd0);

    // Single-cycle shifter instance
    s0_wr_en = 1'b1; s0_wr_addr = 5'd5; s0_wr_dat = 32'hFFFF_FFF8;
    @(negedge Clk);
    s0_wr_addr = 5'd3; s0_wr_dat = 32'd5;
    @(negedge Clk);
    s0_wr_en = 1'b0;
    s0_run("s0_sra", rtype(7'h20, 5'd3, 5'd5, 3'd5, 5'd9), 32'hFFFF_FFF8, 32'd5);
    s0_run("s0_sll", rtype(7'h00, 5'd5, 5'd3, 3'd1, 5'd10), 32'd5, 32'hFFFF_FFF8);

    // Directed: SRA shamt 5, SLTU, ADD under 4-cycle backpressure, SLT, illegal, rd=x0, shamt 0
    issue(rtype(7'h20, 5'd3, 5'd5, 3'd5, 5'd9), 0, 1'b0);
    issue(rtype(7'h00, 5'd4, 5'd5, 3'd3, 5'd6), 1, 1'b0);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 4, 1'b1);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd2, 5'd5), 0, 1'b0);
    issue(rtype(7'h20, 5'd2, 5'd1, 3'd7, 5'd7), 2, 1'b0);
    issue(rtype(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), 0, 1'b0);
    issue(rtype(7'h00, 5'd0, 5'd1, 3'd1, 5'd8), 0, 1'b0);
    wait_idle();
    rd_chk("x20_poke_ignored", 5'd20);
    rd_chk("x0_after_add", 5'd0);

    // Random phase
    for (int r = 1; r < 32; r++) dbg_wr(5'(r), $urandom());
    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 9);
      f7 = (k < 6) ? 7'h00 : (k < 9) ? 7'h20 : 7'($urandom());
      cmd = rtype(f7, 5'($urandom()), 5'($urandom()), 3'($urandom()), 5'($urandom()));
      if ($urandom_range(0, 11) == 0) cmd[6:0] = 7'($urandom());
      issue(cmd, $urandom_range(0, 3), 1'b0);
    end
    wait_idle();
    rd_chk("random_end_x17", 5'd17);

    // Reset in the middle of a serial SLL
    dbg_wr(5'd12, 32'd3);
    dbg_wr(5'd13, 32'd20);
    dbg_wr(5'd14, 32'h1234_5678);
    Command = rtype(7'h00, 5'd13, 5'd12, 3'd1, 5'd14);
    CmdValid = 1'b1;
    @(negedge Clk);
    CmdValid = 1'b0;
    repeat (4) @(negedge Clk);
    RstN = 1'b0;
    @(negedge Clk);
    RstN = 1'b1;
    for (int i = 0; i < 32; i++) ref_rf[i] = 32'd0;
    chk("abort_cmd_ready", CmdReady, 1'b1);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      if (RspValid) seen++;
    end
    chk("abort_no_rsp", seen, 0);
    rd_chk("abort_rd_cleared", 5'd14);
    rd_chk("abort_rs1_cleared", 5'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/big_core_rtype_exec.md
BIG_CORE_RTYPE_EXEC -- requirements
Module: big_core_rtype_exec

Interface
REQ-001 Parameter SERIAL_SHIFT, default 1, meaning 1 = SLL/SRL/SRA shift one bit per cycle, 0 = single-cycle shift.
REQ-002 Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 RstN  input  1  reset, synchronous, active-low.
REQ-004 CmdValid  input  1  Command is presented.
REQ-005 CmdReady  output  1  block accepts Command this cycle.
REQ-006 Command  input  32  RV32 R-type instruction word.
REQ-007 RspValid  output  1  response fields valid.
REQ-008 RspReady  input  1  consumer accepts response.
REQ-009 RspRd  output  5  destination register of the completed command.
REQ-010 RspData  output  32  computed result; 0 when RspIllegal=1.
REQ-011 RspIllegal  output  1  command was not a legal R-type ALU op.
REQ-012 DbgWrEn, DbgWrAddr, DbgWrData  input  1/5/32  register-file preload port.
REQ-013 DbgRdAddr  input  5; DbgRdData  output  32  combinational register-file read.

Function
REQ-014 The block SHALL contain a 32x32 register file with x0 reading 0; writes to x0 SHALL be discarded.
REQ-015 FSM states SHALL be IDLE, EXEC, SHIFT, RESP.
REQ-016 CmdReady SHALL be 1 only in IDLE; a handshake (CmdValid&CmdReady) at cycle T SHALL latch Command and enter EXEC at T+1.
REQ-017 EXEC SHALL read rs1=Command[19:15], rs2=Command[24:20], decode funct7/funct3, and compute the result.
REQ-018 Legal ops: funct7=0000000 with any funct3 (ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND); funct7=0100000 with funct3 000 (SUB) or 101 (SRA); opcode SHALL be 0110011; anything else is illegal.
REQ-019 Arithmetic SHALL be 32-bit modulo; SLT signed, SLTU unsigned, result 0/1 zero-extended; shift amount is rs2[4:0]; SRA sign-fills.
REQ-020 Non-shift legal op or illegal op: EXEC -> RESP, RspValid=1 at T+2.
REQ-021 Shift with SERIAL_SHIFT=1 and shamt n>0: EXEC -> SHIFT for n cycles, one bit per cycle, then RESP; RspValid=1 at T+2+n; shamt=0 SHALL skip SHIFT.
REQ-022 SERIAL_SHIFT=0: shifts SHALL follow REQ-020 timing.
REQ-023 Writeback of a legal result to rd SHALL occur on the edge entering RESP, so DbgRdData reflects it while RspValid=1; illegal ops SHALL write nothing.
REQ-024 RESP SHALL hold RspValid, RspRd, RspData, RspIllegal stable until RspReady=1; then IDLE next cycle (no CmdReady in the same cycle).
REQ-025 DbgWrEn SHALL take effect only in IDLE and be ignored in other states.
REQ-026 RspValid, RspIllegal SHALL be 0 and RspRd, RspData 0 outside RESP.

Reset
REQ-027 While RstN=0 at a rising edge: state=IDLE, CmdReady=1 after release, RspValid=0, RspRd=0, RspData=0, RspIllegal=0, shift counter=0.
REQ-028 Reset SHALL clear all register-file entries to 0.
REQ-029 Reset asserted mid-EXEC/SHIFT/RESP SHALL abort the command with no writeback and no response.

Structure
REQ-030 Package big_core_pkg SHALL hold the R-type opcode constant, funct3/funct7 constants, and the FSM state enum.
REQ-031 Register file SHALL be sub-module big_core_rtype_rf (2 comb reads, 1 sync write, x0 zero); ALU/FSM stay in the top.

Verification
REQ-032 Preload x1=10,x2=20,x3=5,x5=0xFFFFFFF8; ADD rd=3 rs1=1 rs2=2 accepted at T -> RspValid at T+2, RspData=30, x3=30.
REQ-033 SRA rd=9 rs1=5 rs2=3 (shamt 5), SERIAL_SHIFT=1 -> RspValid at T+7, RspData=0xFFFFFFFF; SERIAL_SHIFT=0 -> T+2.
REQ-034 SLTU rd=6 rs1=5 rs2=4 (x4=15) -> RspData=0; SLT rd=5 rs1=1 rs2=2 -> RspData=1.
REQ-035 funct7=0100000 funct3=111 -> RspIllegal=1, RspData=0, rd unchanged; write to x0 via ADD -> x0 still reads 0.
REQ-036 RspReady held 0 for 4 cycles -> response fields stable, CmdReady=0, next command accepted only after RspReady handshake.
REQ-037 RstN=0 during SHIFT of SLL -> no RspValid, rd unchanged (register file cleared), IDLE with CmdReady=1 after release.
